// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode mnemonics and controller states.
// The DIV/REM datapath is present only when SEQ_ALU_DIV_EN is defined.
package seq_alu_pkg;

   typedef enum logic [3:0] {
      ADD = 4'd0,  SUB = 4'd1,  LSH = 4'd2,  RSH = 4'd3,
      AND = 4'd4,  OR  = 4'd5,  XOR = 4'd6,  NEG = 4'd7,
      GEQ = 4'd8,  EQ  = 4'd9,  NEQ = 4'd10, BNZ = 4'd11,
      MUL = 4'd12, DIV = 4'd13, REM = 4'd14, NOP = 4'd15
   } op_mne;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state;

   localparam int FLAGS_W = 4;

endpackage

// File: rtl/iter_muldiv.sv
// W-cycle iterative unit: unsigned shift-add multiply and, with SEQ_ALU_DIV_EN,
// unsigned restoring divide. o_lo/o_hi present the result of the step in progress.
module iter_muldiv #(
   parameter int W = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         i_start,
`ifdef SEQ_ALU_DIV_EN
   input  logic         i_div,
`endif
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_done,
   output logic [W-1:0] o_lo,
   output logic [W-1:0] o_hi
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic          r_busy;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_acc;
   logic [W-1:0]  r_q;
   logic [W-1:0]  r_m;
   logic [W:0]    w_sum;
   logic [W-1:0]  w_acc_n;
   logic [W-1:0]  w_q_n;
`ifdef SEQ_ALU_DIV_EN
   logic          r_div;
   logic [W:0]    w_shl;
   logic [W-1:0]  w_dif;
`endif

   // r_acc holds the product high half (or partial remainder); r_q the low half (or quotient).
   always_comb begin
      w_sum   = {1'b0, r_acc} + {1'b0, r_m & {W{r_q[0]}}};
      w_acc_n = w_sum[W:1];
      w_q_n   = {w_sum[0], r_q[W-1:1]};
`ifdef SEQ_ALU_DIV_EN
      w_shl = {r_acc, r_q[W-1]};
      w_dif = w_shl[W-1:0] - r_m;
      if (r_div) begin
         if (w_shl >= {1'b0, r_m}) begin
            w_acc_n = w_dif;
            w_q_n   = {r_q[W-2:0], 1'b1};
         end else begin
            w_acc_n = w_shl[W-1:0];
            w_q_n   = {r_q[W-2:0], 1'b0};
         end
      end
`endif
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_acc  <= '0;
         r_q    <= '0;
         r_m    <= '0;
`ifdef SEQ_ALU_DIV_EN
         r_div  <= 1'b0;
`endif
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_cnt  <= '0;
         r_acc  <= '0;
         r_q    <= i_a;
         r_m    <= i_b;
`ifdef SEQ_ALU_DIV_EN
         r_div  <= i_div;
`endif
      end else if (r_busy) begin
         r_acc <= w_acc_n;
         r_q   <= w_q_n;
         r_cnt <= r_cnt + CW'(1);
         if (r_cnt == LAST) r_busy <= 1'b0;
      end
   end

   assign o_done = r_busy && (r_cnt == LAST);
   assign o_lo   = w_q_n;
   assign o_hi   = w_acc_n;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with IDLE/BUSY/DONE controller; MUL (and DIV/REM when
// SEQ_ALU_DIV_EN is defined) run W cycles in iter_muldiv, the rest finish in one.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int W   = 8,
   parameter int Ops = 4
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               InValid,
   output logic               InReady,
   input  logic [Ops-1:0]     OP,
   input  logic [W-1:0]       InputA,
   input  logic [W-1:0]       InputB,
   output logic               OutValid,
   output logic [W-1:0]       Out,
   output logic [W-1:0]       OutHi,
   output logic               Branch,
   output logic [FLAGS_W-1:0] Flags,
   output alu_state           DbgState
);

   // Handshake: a request is taken on a rising edge where InValid && InReady;
   // OutValid is a one-cycle pulse and is never back-pressured.
   alu_state           r_state, w_state_n;
   op_mne              r_op;
   op_mne              w_op;
   logic [W-1:0]       r_out, r_hi;
   logic               r_br;
   logic [FLAGS_W-1:0] r_flags;
   logic               w_start, w_load, w_iter;
   logic [W:0]         w_sum;
   logic [W-1:0]       w_res, w_hi;
   logic               w_br, w_ill, w_carry;
   logic               w_it_done;
   logic [W-1:0]       w_it_lo, w_it_hi;

   assign w_op = op_mne'(OP[3:0]);

`ifdef SEQ_ALU_DIV_EN
   assign w_iter = (w_op == MUL) || (((w_op == DIV) || (w_op == REM)) && (InputB != '0));
`else
   assign w_iter = (w_op == MUL);
`endif

   always_comb begin
      w_sum   = {1'b0, InputA} + {1'b0, InputB};
      w_res   = '0;
      w_hi    = '0;
      w_br    = 1'b0;
      w_ill   = 1'b0;
      w_carry = 1'b0;
      if (r_state == BUSY) begin
         w_res = (r_op == REM) ? w_it_hi : w_it_lo;
         w_hi  = (r_op == MUL) ? w_it_hi : '0;
      end else begin
         case (w_op)
            ADD: begin w_res = w_sum[W-1:0]; w_carry = w_sum[W]; end
            SUB: begin w_res = InputA - InputB; w_carry = (InputA < InputB); end
            LSH: w_res = {InputA[W-2:0], 1'b0};
            RSH: w_res = {1'b0, InputA[W-1:1]};
            AND: w_res = InputA & InputB;
            OR:  w_res = InputA | InputB;
            XOR: w_res = InputA ^ InputB;
            NEG: w_res = -InputA;
            GEQ: w_res = {{(W-1){1'b0}}, InputA >= InputB};
            EQ:  w_res = {{(W-1){1'b0}}, InputA == InputB};
            NEQ: w_res = {{(W-1){1'b0}}, InputA != InputB};
            BNZ: w_br  = (InputA != '0);
`ifdef SEQ_ALU_DIV_EN
            DIV, REM: begin
               // Only the divide-by-zero case lands here; others go to the iterator.
               w_ill = 1'b1;
               w_res = (w_op == DIV) ? '1 : InputA;
            end
`else
            DIV, REM: w_ill = 1'b1;
`endif
            default: w_res = '0;
         endcase
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_start   = 1'b0;
      w_load    = 1'b0;
      case (r_state)
         IDLE: if (InValid) begin
            if (w_iter) begin
               w_start   = 1'b1;
               w_state_n = BUSY;
            end else begin
               w_load    = 1'b1;
               w_state_n = DONE;
            end
         end
         BUSY: if (w_it_done) begin
            w_load    = 1'b1;
            w_state_n = DONE;
         end
         DONE:    w_state_n = IDLE;
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
         r_op    <= NOP;
         r_out   <= '0;
         r_hi    <= '0;
         r_br    <= 1'b0;
         r_flags <= '0;
      end else begin
         r_state <= w_state_n;
         if (w_start) r_op <= w_op;
         if (w_load) begin
            r_out   <= w_res;
            r_hi    <= w_hi;
            r_br    <= w_br;
            r_flags <= {w_ill, w_res[W-1], w_carry, (w_res == '0)};
         end
      end
   end

   iter_muldiv #(.W(W)) u_iter (
      .Clk     (Clk),
      .Reset   (Reset),
      .i_start (w_start),
`ifdef SEQ_ALU_DIV_EN
      .i_div   (w_op != MUL),
`endif
      .i_a     (InputA),
      .i_b     (InputB),
      .o_done  (w_it_done),
      .o_lo    (w_it_lo),
      .o_hi    (w_it_hi)
   );

   assign InReady  = (r_state == IDLE);
   assign OutValid = (r_state == DONE);
   assign Out      = r_out;
   assign OutHi    = r_hi;
   assign Branch   = r_br;
   assign Flags    = r_flags;
   assign DbgState = r_state;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu (W=8) against an arithmetic reference model.
module tb_seq_alu;
   import seq_alu_pkg::*;

   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;

   typedef struct {
      int out;
      int hi;
      int br;
      int flags;
      int lat;
      int due;
   } exp_t;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         InValid;
   logic         InReady;
   logic [3:0]   OP;
   logic [W-1:0] InputA, InputB;
   logic         OutValid;
   logic [W-1:0] Out, OutHi;
   logic         Branch;
   logic [3:0]   Flags;
   alu_state     DbgState;

   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   exp_t exp_q[$];
   int   held_out = 0, held_hi = 0, held_br = 0, held_flags = 0;

   seq_alu #(.W(W), .Ops(4)) dut (
      .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady), .OP(OP),
      .InputA(InputA), .InputB(InputB), .OutValid(OutValid), .Out(Out),
      .OutHi(OutHi), .Branch(Branch), .Flags(Flags), .DbgState(DbgState)
   );

   // clock / reset
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference model from the operation definitions
   function automatic exp_t model(input int op, input int a, input int b);
      exp_t e;
      int ill, car;
      ill = 0; car = 0;
      e.out = 0; e.hi = 0; e.br = 0; e.lat = 1; e.due = 0;
      case (op)
         0:  begin e.out = (a + b) & MASK; car = ((a + b) > MASK) ? 1 : 0; end
         1:  begin e.out = (a - b) & MASK; car = (a < b) ? 1 : 0; end
         2:  e.out = (a * 2) & MASK;
         3:  e.out = a / 2;
         4:  e.out = a & b;
         5:  e.out = a | b;
         6:  e.out = a ^ b;
         7:  e.out = (0 - a) & MASK;
         8:  e.out = (a >= b) ? 1 : 0;
         9:  e.out = (a == b) ? 1 : 0;
         10: e.out = (a != b) ? 1 : 0;
         11: e.br  = (a != 0) ? 1 : 0;
         12: begin e.out = (a * b) % (1 << W); e.hi = (a * b) / (1 << W); e.lat = W + 1; end
`ifdef SEQ_ALU_DIV_EN
         13: if (b == 0) begin e.out = MASK; ill = 1; end
             else begin e.out = a / b; e.lat = W + 1; end
         14: if (b == 0) begin e.out = a; ill = 1; end
             else begin e.out = a % b; e.lat = W + 1; end
`else
         13, 14: ill = 1;
`endif
         default: e.out = 0;
      endcase
      e.flags = ill * 8 + ((e.out >> (W - 1)) & 1) * 4 + car * 2 + ((e.out == 0) ? 1 : 0);
      return e;
   endfunction

   // driver: waits for InReady (injecting ignored noise meanwhile), then issues one request
   task automatic issue(input int op, input int a, input int b);
      int   guard;
      bit   ready;
      exp_t e;
      guard = 0; ready = 1'b0;
      while (!ready && guard < 200) begin
         @(negedge Clk);
         guard++;
         if (InReady) ready = 1'b1;
         else begin
            InValid = 1'($urandom_range(0, 1));
            OP      = 4'($urandom);
            InputA  = W'($urandom);
            InputB  = W'($urandom);
         end
      end
      if (!ready) begin
         n_checks++; n_err++;
         $display("FAIL issue_timeout: InReady low for %0d cycles, required high", guard);
         InValid = 1'b0;
         return;
      end
      InValid = 1'b1;
      OP      = 4'(op);
      InputA  = W'(a);
      InputB  = W'(b);
      @(posedge Clk);
      #1;
      InValid = 1'b0;
      e = model(op, a, b);
      e.due = cyc + e.lat - 1;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 60) begin
         @(negedge Clk);
         guard++;
      end
      #1;
      if (exp_q.size() != 0) begin
         n_checks++; n_err++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // scoreboard: checks handshake and outputs every cycle out of reset
   always @(negedge Clk) begin
      if (Reset === 1'b0) begin
         bit   busy, exp_valid;
         exp_t e;
         busy      = (exp_q.size() != 0);
         exp_valid = busy && (exp_q[0].due == cyc);
         chk("out_valid", int'(OutValid), int'(exp_valid));
         chk("in_ready", int'(InReady), int'(!busy));
         if (!busy) chk("state_idle", int'(DbgState), int'(IDLE));
         if (exp_valid) begin
            e = exp_q.pop_front();
            held_out = e.out; held_hi = e.hi; held_br = e.br; held_flags = e.flags;
         end
         chk("out", int'(Out), held_out);
         chk("out_hi", int'(OutHi), held_hi);
         chk("branch", int'(Branch), held_br);
         chk("flags", int'(Flags), held_flags);
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      Reset = 1'b1; InValid = 1'b0; OP = '0; InputA = '0; InputB = '0;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      chk("rst_out", int'(Out), 0);
      chk("rst_flags", int'(Flags), 0);
      chk("rst_valid", int'(OutValid), 0);
      chk("rst_ready", int'(InReady), 1);

      // model pins, hand-computed
      e = model(0, 'hF0, 'h20);
      chk("pin_add_out", e.out, 'h10); chk("pin_add_flags", e.flags, 'h2); chk("pin_add_lat", e.lat, 1);
      e = model(12, 'hFF, 'hFF);
      chk("pin_mul_lo", e.out, 'h01); chk("pin_mul_hi", e.hi, 'hFE); chk("pin_mul_lat", e.lat, 9);
`ifdef SEQ_ALU_DIV_EN
      e = model(13, 100, 7);  chk("pin_div", e.out, 14);
      e = model(14, 100, 7);  chk("pin_rem", e.out, 2);
      e = model(13, 5, 0);    chk("pin_div0", e.out, 'hFF); chk("pin_div0_flags", e.flags, 'hC);
      chk("pin_div0_lat", e.lat, 1);
`else
      e = model(13, 100, 7);  chk("pin_nodiv", e.out, 0); chk("pin_nodiv_flags", e.flags, 'h9);
      chk("pin_nodiv_lat", e.lat, 1);
`endif
      e = model(11, 0, 0);    chk("pin_bnz0", e.br, 0);
      e = model(11, 1, 0);    chk("pin_bnz1", e.br, 1);

      // directed transactions
      issue(0, 'hF0, 'h20); wait_idle(); chk("dir_add_out", int'(Out), 'h10);
      issue(12, 'hFF, 'hFF); wait_idle();
      chk("dir_mul_lo", int'(Out), 'h01); chk("dir_mul_hi", int'(OutHi), 'hFE);
      issue(13, 100, 7); issue(14, 100, 7); issue(13, 5, 0); issue(14, 9, 0);
      issue(11, 0, 0); issue(11, 1, 0); wait_idle();
      chk("dir_bnz1", int'(Branch), 1);

      // reset 3 cycles into a multiply
      issue(12, 'h37, 'h5A);
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b1;
      exp_q.delete();
      held_out = 0; held_hi = 0; held_br = 0; held_flags = 0;
      #1;
      chk("abort_state", int'(DbgState), int'(IDLE));
      chk("abort_valid", int'(OutValid), 0);
      chk("abort_out", int'(Out), 0);
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      repeat (12) @(posedge Clk);
      issue(0, 1, 1); wait_idle(); chk("post_rst_add", int'(Out), 2);

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         int op, a, b;
         op = $urandom_range(0, 15);
         a  = $urandom_range(0, MASK);
         b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MASK);
         if ($urandom_range(0, 3) == 0) a = (a & 1) ? MASK : 0;
         issue(op, a, b);
         repeat ($urandom_range(0, 2)) @(posedge Clk);
      end
      wait_idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
